// File: rtl/serial_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : serial_pattern_gen
//  Purpose  : Parallel-to-serial stimulus source for the serial sequence
//             detector. Accepts a word plus length over a valid/ready load
//             handshake and shifts it out MSB-first, one bit every DIV
//             cycles. Supports gapless back-to-back words and auto-repeat.
//  Revision : 1.0  initial release
// ============================================================================
module serial_pattern_gen #(
  parameter int WIDTH = 16,
  parameter int DIV   = 1,
  parameter int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             repeat_en,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int               PER_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(DIV - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(WIDTH);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]       state_q,   state_d;
  logic [WIDTH-1:0] word_q,    word_d;     // captured word, MSB-aligned
  logic [LEN_W-1:0] len_q,     len_d;      // captured (clamped) length
  logic [WIDTH-1:0] sh_q,      sh_d;       // current bit always at MSB
  logic [LEN_W-1:0] bit_q,     bit_d;      // remaining bits after current
  logic [PER_W-1:0] per_q,     per_d;      // cycle within current bit period
  logic             x_q,       x_d;
  logic             x_valid_q, x_valid_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;

  logic [LEN_W-1:0] w_len;
  logic [LEN_W-1:0] w_shamt;
  logic [WIDTH-1:0] w_aligned;
  logic             w_accept;

  // done_q is high exactly in the final cycle of a word, which is also the
  // only SHIFT cycle in which a new word may be accepted.
  assign load_ready = (state_q == S_IDLE) || done_q;
  assign w_accept   = load_valid && load_ready;

  // Next-state logic: capture, shift, repeat or return to idle. Outputs are
  // derived from the next state so that they can be registered directly.
  always_comb begin
    w_len     = ((load_len == '0) || (load_len > LEN_MAX)) ? LEN_MAX : load_len;
    w_shamt   = LEN_MAX - w_len;
    w_aligned = load_data << w_shamt;

    state_d = state_q;
    word_d  = word_q;
    len_d   = len_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    per_d   = per_q;

    if (w_accept) begin
      state_d = S_SHIFT;
      word_d  = w_aligned;
      len_d   = w_len;
      sh_d    = w_aligned;
      bit_d   = w_len - 1'b1;
      per_d   = '0;
    end else if (state_q == S_SHIFT) begin
      if (per_q == PER_LAST) begin
        per_d = '0;
        if (bit_q == '0) begin
          if (repeat_en) begin
            sh_d  = word_q;
            bit_d = len_q - 1'b1;
          end else begin
            state_d = S_IDLE;
            sh_d    = '0;
            bit_d   = '0;
          end
        end else begin
          sh_d  = sh_q << 1;
          bit_d = bit_q - 1'b1;
        end
      end else begin
        per_d = per_q + 1'b1;
      end
    end

    x_d       = (state_d == S_SHIFT) && sh_d[WIDTH-1];
    x_valid_d = (state_d == S_SHIFT);
    busy_d    = (state_d == S_SHIFT);
    done_d    = (state_d == S_SHIFT) && (bit_d == '0) && (per_d == PER_LAST);
  end

  // State and registered outputs; reset abandons any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      word_q    <= '0;
      len_q     <= '0;
      sh_q      <= '0;
      bit_q     <= '0;
      per_q     <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      len_q     <= len_d;
      sh_q      <= sh_d;
      bit_q     <= bit_d;
      per_q     <= per_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_pattern_gen
//  Purpose  : Directed self-checking bench for serial_pattern_gen, with one
//             instance at DIV=1 and one at DIV=4.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ld_data;
  logic [4:0]  ld_len;
  logic        lv1, lv4, rep;
  logic        rdy1, x1, xv1, busy1, done1;
  logic        rdy4, x4, xv4, busy4, done4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_pattern_gen #(.WIDTH(16), .DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .load_data(ld_data), .load_len(ld_len),
    .load_valid(lv1), .load_ready(rdy1), .repeat_en(rep),
    .x(x1), .x_valid(xv1), .busy(busy1), .done(done1)
  );

  serial_pattern_gen #(.WIDTH(16), .DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .load_data(ld_data), .load_len(ld_len),
    .load_valid(lv4), .load_ready(rdy4), .repeat_en(1'b0),
    .x(x4), .x_valid(xv4), .busy(busy4), .done(done4)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] e7;

    rst = 1'b1; ld_data = '0; ld_len = '0; lv1 = 1'b0; lv4 = 1'b0; rep = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    check_val("rst_rdy", rdy1, 1); check_val("rst_x", x1, 0);
    check_val("rst_xv", xv1, 0);   check_val("rst_busy", busy1, 0);
    check_val("rst_done", done1, 0);

    // Basic word 7'b1101010
    e7 = 7'b1101010;
    ld_data = 16'h006A; ld_len = 5'd7; lv1 = 1'b1;
    tick();
    lv1 = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      check_val($sformatf("basic_x_c%0d", i), x1, e7[7-i]);
      check_val($sformatf("basic_xv_c%0d", i), xv1, 1);
      check_val($sformatf("basic_busy_c%0d", i), busy1, 1);
      check_val($sformatf("basic_done_c%0d", i), done1, (i == 7));
      check_val($sformatf("basic_rdy_c%0d", i), rdy1, (i == 7));
      tick();
    end
    check_val("basic_end_x", x1, 0); check_val("basic_end_xv", xv1, 0);
    check_val("basic_end_rdy", rdy1, 1); check_val("basic_end_done", done1, 0);

    // Back-to-back: A=101 (len 3), then B=1110 (len 4)
    e7 = 7'b1011110;
    ld_data = 16'h0005; ld_len = 5'd3; lv1 = 1'b1;
    tick();
    for (int i = 1; i <= 7; i++) begin
      if (i == 3) begin ld_data = 16'h000E; ld_len = 5'd4; end
      if (i == 4) lv1 = 1'b0;
      check_val($sformatf("b2b_x_c%0d", i), x1, e7[7-i]);
      check_val($sformatf("b2b_xv_c%0d", i), xv1, 1);
      check_val($sformatf("b2b_done_c%0d", i), done1, (i == 3 || i == 7));
      tick();
    end
    check_val("b2b_end_xv", xv1, 0);

    // Repeat: 2'b10 replayed until repeat_en drops
    ld_data = 16'h0002; ld_len = 5'd2; lv1 = 1'b1; rep = 1'b1;
    tick();
    lv1 = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      if (i == 5) rep = 1'b0;
      check_val($sformatf("rep_x_c%0d", i), x1, (i % 2 == 1));
      check_val($sformatf("rep_xv_c%0d", i), xv1, 1);
      check_val($sformatf("rep_done_c%0d", i), done1, (i % 2 == 0));
      tick();
    end
    check_val("rep_end_xv", xv1, 0); check_val("rep_end_busy", busy1, 0);

    // DIV=4: 3'b110
    ld_data = 16'h0006; ld_len = 5'd3; lv4 = 1'b1;
    tick();
    lv4 = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      check_val($sformatf("div4_x_c%0d", i), x4, (i <= 8));
      check_val($sformatf("div4_xv_c%0d", i), xv4, 1);
      check_val($sformatf("div4_rdy_c%0d", i), rdy4, (i == 12));
      check_val($sformatf("div4_done_c%0d", i), done4, (i == 12));
      tick();
    end
    check_val("div4_end_xv", xv4, 0); check_val("div4_end_rdy", rdy4, 1);

    // Clamp len=0 -> 16 bits of 16'h8001
    ld_data = 16'h8001; ld_len = 5'd0; lv1 = 1'b1;
    tick();
    lv1 = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      check_val($sformatf("clamp0_x_c%0d", i), x1, (i == 1 || i == 16));
      check_val($sformatf("clamp0_done_c%0d", i), done1, (i == 16));
      tick();
    end
    check_val("clamp0_end_xv", xv1, 0);

    // Clamp len>WIDTH -> 16 bits
    ld_data = 16'h8000; ld_len = 5'd31; lv1 = 1'b1;
    tick();
    lv1 = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      check_val($sformatf("clampbig_x_c%0d", i), x1, (i == 1));
      check_val($sformatf("clampbig_done_c%0d", i), done1, (i == 16));
      tick();
    end
    check_val("clampbig_end_xv", xv1, 0);

    // len=1
    ld_data = 16'h0001; ld_len = 5'd1; lv1 = 1'b1;
    tick();
    lv1 = 1'b0;
    check_val("len1_x", x1, 1); check_val("len1_xv", xv1, 1);
    check_val("len1_done", done1, 1); check_val("len1_rdy", rdy1, 1);
    tick();
    check_val("len1_end_xv", xv1, 0); check_val("len1_end_done", done1, 0);

    // Async reset mid-word
    ld_data = 16'h006A; ld_len = 5'd7; lv1 = 1'b1;
    tick();
    lv1 = 1'b0;
    tick(); tick(); tick();
    check_val("ar_pre_x", x1, 1); check_val("ar_pre_busy", busy1, 1);
    #2 rst = 1'b1;
    #1;
    check_val("ar_x", x1, 0); check_val("ar_xv", xv1, 0);
    check_val("ar_busy", busy1, 0); check_val("ar_done", done1, 0);
    check_val("ar_rdy", rdy1, 1);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val($sformatf("ar_post_done_%0d", i), done1, 0);
      check_val($sformatf("ar_post_xv_%0d", i), xv1, 0);
    end
    check_val("ar_post_rdy", rdy1, 1);
    e7 = 7'b1101010;
    ld_data = 16'h006A; ld_len = 5'd7; lv1 = 1'b1;
    tick();
    lv1 = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      check_val($sformatf("ar_fresh_x_c%0d", i), x1, e7[7-i]);
      check_val($sformatf("ar_fresh_xv_c%0d", i), xv1, 1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
